// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - shared types and constants for the shared register arbiter
// Contents: default register width, sequencer state encoding, core op encoding.
package shared_reg_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic OP_FETCH_INC = 1'b0;
    localparam logic OP_SWAP      = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select over NUM_CORES requesters
// Ports:
//   i_req       in   NUM_CORES  request vector
//   i_rr_ptr    in   IDX_W      index where the search starts (highest priority)
//   o_grant_idx out  IDX_W      first requesting index at or after i_rr_ptr (wrapping)
//   o_any_req   out  1          at least one request is present
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]     i_rr_ptr,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_any_req
);

    int               w_pos;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_grant_idx = '0;
        o_any_req   = 1'b0;
        w_pos       = 0;
        w_sel       = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            // Walk the ring starting at the pointer; modulo done by a single
            // subtract since the pointer is always below NUM_CORES.
            w_pos = int'(i_rr_ptr) + k;
            if (w_pos >= NUM_CORES) begin
                w_pos = w_pos - NUM_CORES;
            end
            w_sel = IDX_W'(w_pos);
            if (!o_any_req && i_req[w_sel]) begin
                o_any_req   = 1'b1;
                o_grant_idx = w_sel;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin sequencer sharing one fetch-inc/swap register
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   core_req/op/wdata per-core request, op (0 fetch-inc, 1 swap), write data slice
//   core_ack/rdata    one-hot one-cycle completion, pre-operation register value
//   busy              high while an op is in ISSUE or ACK
//   reg_write_en/reg_inc_en/reg_data_in  controls to the shared register
//   reg_data_out      current shared register value
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_op,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        busy,
    output logic                        reg_write_en,
    output logic                        reg_inc_en,
    output logic [DATA_W-1:0]           reg_data_in,
    input  logic [DATA_W-1:0]           reg_data_out
);

    localparam int IDX_W = $clog2(NUM_CORES);

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0]     r_grant_idx, w_grant_idx_nxt;
    logic                 r_write_en, w_write_en_nxt;
    logic                 r_inc_en, w_inc_en_nxt;
    logic                 r_busy, w_busy_nxt;
    logic [DATA_W-1:0]    r_data_in, w_data_in_nxt;
    logic [DATA_W-1:0]    r_rdata, w_rdata_nxt;
    logic [NUM_CORES-1:0] r_ack, w_ack_nxt;

    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_any_req;
    logic                 w_sel_op;
    logic [DATA_W-1:0]    w_sel_wdata;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .i_req       (core_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_idx (w_arb_idx),
        .o_any_req   (w_any_req)
    );

    // Op and write data of the arbitration winner, only consumed in IDLE.
    always_comb begin
        w_sel_op    = core_op[w_arb_idx];
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_arb_idx == IDX_W'(i)) begin
                w_sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_data_in_nxt   = r_data_in;
        w_rdata_nxt     = r_rdata;
        w_write_en_nxt  = 1'b0;
        w_inc_en_nxt    = 1'b0;
        w_busy_nxt      = 1'b0;
        w_ack_nxt       = '0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = ISSUE;
                    w_grant_idx_nxt = w_arb_idx;
                    w_busy_nxt      = 1'b1;
                    if (w_sel_op == OP_SWAP) begin
                        w_write_en_nxt = 1'b1;
                        w_data_in_nxt  = w_sel_wdata;
                    end else begin
                        w_inc_en_nxt   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // The register updates on this same edge, so reg_data_out
                // still shows the pre-operation value here.
                w_state_nxt            = ACK;
                w_rdata_nxt            = reg_data_out;
                w_ack_nxt[r_grant_idx] = 1'b1;
                w_busy_nxt             = 1'b1;
                w_rr_ptr_nxt           = (r_grant_idx == IDX_W'(NUM_CORES - 1))
                                         ? '0 : r_grant_idx + IDX_W'(1);
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_write_en  <= 1'b0;
            r_inc_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_data_in   <= '0;
            r_rdata     <= '0;
            r_ack       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_write_en  <= w_write_en_nxt;
            r_inc_en    <= w_inc_en_nxt;
            r_busy      <= w_busy_nxt;
            r_data_in   <= w_data_in_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ack       <= w_ack_nxt;
        end
    end

    assign core_ack     = r_ack;
    assign core_rdata   = r_rdata;
    assign busy         = r_busy;
    assign reg_write_en = r_write_en;
    assign reg_inc_en   = r_inc_en;
    assign reg_data_in  = r_data_in;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] core_req;
    logic [N-1:0] core_op;
    logic [N*W-1:0] core_wdata;
    logic [N-1:0] core_ack;
    logic [W-1:0] core_rdata;
    logic         busy;
    logic         reg_write_en;
    logic         reg_inc_en;
    logic [W-1:0] reg_data_in;
    logic [W-1:0] sh_reg;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] m_reg;
    int           m_ptr;

    int           obs_n;
    int           obs_core [8];
    logic [W-1:0] obs_rd   [8];
    int           obs_cyc  [8];
    logic [W-1:0] obs_din  [8];
    int           obs_we, obs_inc, obs_both, obs_busy_err, obs_hot_err;
    bit           obs_timeout;

    shared_reg_arbiter #(.NUM_CORES(N), .DATA_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req     (core_req),
        .core_op      (core_op),
        .core_wdata   (core_wdata),
        .core_ack     (core_ack),
        .core_rdata   (core_rdata),
        .busy         (busy),
        .reg_write_en (reg_write_en),
        .reg_inc_en   (reg_inc_en),
        .reg_data_in  (reg_data_in),
        .reg_data_out (sh_reg)
    );

    always #5 clk = ~clk;

    // The shared register itself; not reset by the arbiter.
    always_ff @(posedge clk) begin
        if (reg_write_en) sh_reg <= reg_data_in;
        else if (reg_inc_en) sh_reg <= sh_reg + 16'd1;
    end

    function automatic int model_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c = (ptr + k) % N;
            if (((mask >> c) & 4'b1) != 4'b0) return c;
        end
        return -1;
    endfunction

    task automatic model_apply(input int c, input logic [3:0] ops, input logic [63:0] wd,
                               output logic [W-1:0] rd, output logic op, output logic [W-1:0] wdc);
        logic [63:0] t;
        t   = wd >> (16 * c);
        wdc = t[15:0];
        op  = ((ops >> c) & 4'b1) != 4'b0;
        rd  = m_reg;
        m_reg = op ? wdc : m_reg + 16'd1;
        m_ptr = (c + 1) % N;
    endtask

    // Raise a set of requests and record every ack until all are served.
    task automatic run_multi(input logic [3:0] mask, input logic [3:0] ops,
                             input logic [63:0] wd, input bit scramble);
        logic [3:0] pending;
        int cyc;
        @(negedge clk);
        core_op = ops; core_wdata = wd; core_req = mask; pending = mask;
        obs_n = 0; obs_we = 0; obs_inc = 0; obs_both = 0; obs_busy_err = 0; obs_hot_err = 0;
        cyc = 0;
        while (pending != 4'b0 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (reg_write_en && reg_inc_en) obs_both++;
            if (reg_write_en) begin
                obs_we++;
                if (obs_n < 8) obs_din[obs_n] = reg_data_in;
            end
            if (reg_inc_en) obs_inc++;
            if (busy !== (reg_write_en | reg_inc_en | (|core_ack))) obs_busy_err++;
            if (scramble && (reg_write_en || reg_inc_en)) begin
                core_op = 4'($urandom); core_wdata = {$urandom, $urandom};
            end
            if (core_ack != 4'b0) begin
                if ($countones(core_ack) != 1) obs_hot_err++;
                if (obs_n < 8) begin
                    obs_core[obs_n] = -1;
                    for (int i = 0; i < N; i++) if (core_ack == (4'b1 << i)) obs_core[obs_n] = i;
                    obs_rd[obs_n]  = core_rdata;
                    obs_cyc[obs_n] = cyc;
                end
                obs_n++;
                pending  = pending & ~core_ack;
                core_req = core_req & ~core_ack;
            end
        end
        obs_timeout = (pending != 4'b0);
        core_req = 4'b0;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; core_req = '0; core_op = '0; core_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (core_ack !== 4'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ack_busy: ack=%b busy=%b expected 0000/0", core_ack, busy);
        end
        tests_run++;
        if (reg_write_en !== 1'b0 || reg_inc_en !== 1'b0) begin
            tests_failed++; $display("FAIL reset_enables: we=%b inc=%b expected 0/0", reg_write_en, reg_inc_en);
        end
        tests_run++;
        if (core_rdata !== 16'h0 || reg_data_in !== 16'h0) begin
            tests_failed++; $display("FAIL reset_data: rdata=%h din=%h expected 0/0", core_rdata, reg_data_in);
        end
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_fetch;
        run_multi(4'b1000, 4'b1000, 64'h0, 1'b0);
        tests_run++;
        if (sh_reg !== 16'h0000) begin
            tests_failed++; $display("FAIL init_write: reg=%h expected 0000", sh_reg);
        end
        run_multi(4'b0001, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_timeout || obs_n != 1 || obs_core[0] != 0 || obs_cyc[0] != 2) begin
            tests_failed++; $display("FAIL fetch_ack: n=%0d core=%0d cyc=%0d expected 1/0/2", obs_n, obs_core[0], obs_cyc[0]);
        end
        tests_run++;
        if (obs_inc != 1 || obs_we != 0) begin
            tests_failed++; $display("FAIL fetch_enable: inc_cycles=%0d we_cycles=%0d expected 1/0", obs_inc, obs_we);
        end
        tests_run++;
        if (obs_rd[0] !== 16'h0000 || sh_reg !== 16'h0001) begin
            tests_failed++; $display("FAIL fetch_value: rdata=%h reg=%h expected 0000/0001", obs_rd[0], sh_reg);
        end
    endtask

    task automatic test_swap;
        run_multi(4'b0010, 4'b0010, {16'h0, 16'h0, 16'h0005, 16'h0}, 1'b0);
        run_multi(4'b0100, 4'b0100, {16'h0, 16'h1234, 16'h0, 16'h0}, 1'b1);
        tests_run++;
        if (obs_timeout || obs_n != 1 || obs_core[0] != 2 || obs_cyc[0] != 2) begin
            tests_failed++; $display("FAIL swap_ack: n=%0d core=%0d cyc=%0d expected 1/2/2", obs_n, obs_core[0], obs_cyc[0]);
        end
        tests_run++;
        if (obs_we != 1 || obs_inc != 0 || obs_din[0] !== 16'h1234) begin
            tests_failed++; $display("FAIL swap_enable: we=%0d inc=%0d din=%h expected 1/0/1234", obs_we, obs_inc, obs_din[0]);
        end
        tests_run++;
        if (obs_rd[0] !== 16'h0005 || sh_reg !== 16'h1234) begin
            tests_failed++; $display("FAIL swap_value: rdata=%h reg=%h expected 0005/1234", obs_rd[0], sh_reg);
        end
        run_multi(4'b0010, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_n != 1 || obs_core[0] != 1 || obs_rd[0] !== 16'h1234) begin
            tests_failed++; $display("FAIL swap_followup: core=%0d rdata=%h expected 1/1234", obs_core[0], obs_rd[0]);
        end
    endtask

    task automatic test_all_fetch;
        run_multi(4'b1000, 4'b1000, 64'h0, 1'b0);
        run_multi(4'b1111, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_timeout || obs_n != 4 || obs_inc != 4 || sh_reg !== 16'd4) begin
            tests_failed++; $display("FAIL all_fetch_count: n=%0d inc=%0d reg=%h expected 4/4/0004", obs_n, obs_inc, sh_reg);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (obs_core[k] != k || obs_rd[k] !== 16'(k) || obs_cyc[k] != 2 + 3 * k) begin
                tests_failed++;
                $display("FAIL all_fetch_%0d: core=%0d rdata=%h cyc=%0d expected %0d/%h/%0d",
                         k, obs_core[k], obs_rd[k], obs_cyc[k], k, 16'(k), 2 + 3 * k);
            end
        end
    endtask

    task automatic test_fairness;
        run_multi(4'b1001, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_n != 2 || obs_core[0] != 0 || obs_core[1] != 3 || obs_rd[0] !== 16'd4 || obs_rd[1] !== 16'd5) begin
            tests_failed++;
            $display("FAIL fairness: n=%0d order=%0d,%0d rdata=%h,%h expected 2 0,3 0004,0005",
                     obs_n, obs_core[0], obs_core[1], obs_rd[0], obs_rd[1]);
        end
    endtask

    task automatic test_wrap;
        run_multi(4'b0001, 4'b0001, {48'h0, 16'hFFFF}, 1'b0);
        run_multi(4'b0010, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_n != 1 || obs_rd[0] !== 16'hFFFF || sh_reg !== 16'h0000) begin
            tests_failed++; $display("FAIL wrap: rdata=%h reg=%h expected FFFF/0000", obs_rd[0], sh_reg);
        end
    endtask

    task automatic test_reset_issue;
        bit seen;
        int acks;
        seen = 1'b0; acks = 0;
        @(negedge clk);
        core_op = 4'b0000; core_req = 4'b0100;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk); #1;
            if (reg_inc_en) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL rst_issue_enter: inc_seen=%0d expected 1", seen);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (reg_inc_en !== 1'b0 || reg_write_en !== 1'b0 || busy !== 1'b0 || core_ack !== 4'b0 || core_rdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL rst_issue_outputs: inc=%b we=%b busy=%b ack=%b rdata=%h expected 0/0/0/0000/0000",
                     reg_inc_en, reg_write_en, busy, core_ack, core_rdata);
        end
        core_req = 4'b0;
        repeat (3) begin @(posedge clk); #1; if (core_ack != 4'b0) acks++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (core_ack != 4'b0) acks++; end
        tests_run++;
        if (acks != 0 || sh_reg !== 16'h0000) begin
            tests_failed++; $display("FAIL rst_issue_abort: acks=%0d reg=%h expected 0/0000", acks, sh_reg);
        end
        run_multi(4'b1010, 4'b0000, 64'h0, 1'b0);
        tests_run++;
        if (obs_n != 2 || obs_core[0] != 1 || obs_core[1] != 3 || obs_rd[0] !== 16'd0 || obs_cyc[0] != 2) begin
            tests_failed++;
            $display("FAIL rst_issue_after: order=%0d,%0d rdata=%h cyc=%0d expected 1,3/0000/2",
                     obs_core[0], obs_core[1], obs_rd[0], obs_cyc[0]);
        end
    endtask

    task automatic test_random;
        logic [3:0]   mask, ops, pend;
        logic [63:0]  wd;
        logic [W-1:0] exp_rd, wdc;
        logic         op;
        int           c, exp_n;
        m_reg = 16'd2; m_ptr = 0;
        for (int it = 0; it < 25; it++) begin
            mask = 4'($urandom_range(1, 15));
            ops  = 4'($urandom);
            wd   = {$urandom, $urandom};
            run_multi(mask, ops, wd, $countones(mask) == 1);
            exp_n = $countones(mask);
            pend  = mask;
            tests_run++;
            if (obs_timeout || obs_n != exp_n) begin
                tests_failed++; $display("FAIL rand_count[%0d]: acks=%0d expected %0d", it, obs_n, exp_n);
            end
            for (int k = 0; k < exp_n && k < obs_n; k++) begin
                c = model_pick(pend, m_ptr);
                model_apply(c, ops, wd, exp_rd, op, wdc);
                pend = pend & ~(4'b1 << c);
                tests_run++;
                if (obs_core[k] != c || obs_rd[k] !== exp_rd || obs_cyc[k] != 2 + 3 * k) begin
                    tests_failed++;
                    $display("FAIL rand_ack[%0d.%0d]: core=%0d rdata=%h cyc=%0d expected %0d/%h/%0d",
                             it, k, obs_core[k], obs_rd[k], obs_cyc[k], c, exp_rd, 2 + 3 * k);
                end
                if (op) begin
                    tests_run++;
                    if (obs_din[k] !== wdc) begin
                        tests_failed++; $display("FAIL rand_din[%0d.%0d]: din=%h expected %h", it, k, obs_din[k], wdc);
                    end
                end
            end
            tests_run++;
            if (sh_reg !== m_reg || obs_both != 0 || obs_busy_err != 0 || obs_hot_err != 0) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: reg=%h both=%0d busy_err=%0d hot_err=%0d expected %h/0/0/0",
                         it, sh_reg, obs_both, obs_busy_err, obs_hot_err, m_reg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_swap();
        test_all_fetch();
        test_fairness();
        test_wrap();
        test_reset_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and sequencer that lets NUM_CORES cores share one 16-bit write/increment register, such as a shared work-index or lock counter. Each core issues an atomic fetch-and-increment or swap-write. The block grants one core at a time and drives the register's write enable, increment enable and data input. It returns the pre-operation register value to the granted core with a one-cycle ack.

## Interface
- NUM_CORES, default 4, number of requesters (2..8).
- DATA_W, default 16, register width; must match the shared register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request; held high until that core's ack.
- core_op  in  NUM_CORES  per-core op: 0 = fetch-and-increment, 1 = swap-write.
- core_wdata  in  NUM_CORES*DATA_W  per-core write data; core i occupies bits [i*DATA_W +: DATA_W].
- core_ack  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  out  DATA_W  pre-operation register value; valid while any core_ack bit is high.
- busy  out  1  high in ISSUE and ACK.
- reg_write_en  out  1  to register: load reg_data_in.
- reg_inc_en  out  1  to register: increment by 1.
- reg_data_in  out  DATA_W  to register: write data.
- reg_data_out  in  DATA_W  from register: current value, updated on the clk edge after an enable.

## Operation
- FSM states: IDLE, ISSUE, ACK.
- IDLE: if any core_req is high, the round-robin winner is selected starting the search at rr_ptr.
  - Latch grant_idx, op and wdata.
  - Register the matching enable high (reg_inc_en for op 0, reg_write_en for op 1).
  - Register reg_data_in from wdata (op 1 only).
  - Next state ISSUE.
- ISSUE: exactly one enable is high for this single cycle.
  - At the closing edge, capture reg_data_out (the pre-update value) into core_rdata.
  - Drop both enables.
  - Set core_ack[grant_idx].
  - rr_ptr <= (grant_idx+1) mod NUM_CORES.
  - Next state ACK.
- ACK: core_ack one-hot is high for one cycle. Next state is IDLE unconditionally.
- reg_write_en and reg_inc_en are never high together. Only one op is ever in flight.
- Fetch: the core receives the old value V; the register becomes V+1 mod 2^DATA_W (0xFFFF wraps to 0x0000).
- Swap-write: the core receives the old value; the register takes wdata.
- core_op and core_wdata are sampled only at grant. Later changes are ignored.
- A core that drops core_req after grant still receives its ack; the op completes.
- A requester must deassert core_req on the edge ending its ack cycle, so IDLE does not re-grant it.
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE, rr_ptr = 0.
  - core_ack = 0, core_rdata = 0, busy = 0.
  - reg_write_en = 0, reg_inc_en = 0, reg_data_in = 0.
  - An in-flight op is aborted and not acked. The register contents are not reset by this block.

## Timing
- Request sampled at edge E0 (IDLE). Enable high in cycle E0–E1. Register updates and core_rdata is captured at E1. Ack high in cycle E1–E2. IDLE again from E2.
- Latency from request sampled to ack: 2 cycles. Throughput: one op per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- While busy, new requests wait. They are only arbitrated in IDLE.

## Structure
- Shared package shared_reg_pkg holds:
  - DATA_W default.
  - State enum {IDLE, ISSUE, ACK}.
  - Op encoding constants OP_FETCH_INC = 0 and OP_SWAP = 1.
- Sub-module rr_arbiter (NUM_CORES): a combinational round-robin select.
  - Inputs: req vector and rr_ptr.
  - Outputs: grant_idx and any_req.
  - rr_ptr update stays in the parent.

## Test plan
- Write 0x0000, then core0 fetch: reg_inc_en high exactly one cycle, ack0 two cycles after sampling, core_rdata = 0x0000, reg_data_out = 0x0001 afterwards.
- core2 swap-write 0x1234 with the register at 0x0005: reg_write_en one cycle with reg_data_in = 0x1234, core_rdata = 0x0005; a following core1 fetch returns 0x1234.
- After writing 0, all four cores hold fetch requests: acks in order 0,1,2,3 spaced 3 cycles apart, with core_rdata 0,1,2,3 respectively.
- Fairness: after core3 is served, core0 and core3 request together: core0 is acked first, then core3.
- Wrap: swap-write 0xFFFF, then fetch: core_rdata = 0xFFFF and the register reads 0x0000.
- rst_n pulsed low during ISSUE:
  - Enables drop immediately.
  - No ack is issued.
  - rr_ptr = 0 and core_rdata = 0.
  - The next request from core1 with core0 idle is granted normally.
